// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the radix-2 SDF stage sequencer: state encoding,
// frame geometry helpers and twiddle-index composition.
package fft_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BFLY  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Ceiling log2, never below 1 so that degenerate counters keep a legal width.
  function automatic int clog2_min1(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int beats_per_frame(input int n_pt, input int par);
    return n_pt / par;
  endfunction

  function automatic int blks_per_frame(input int n_pt, input int par, input int half);
    return n_pt / (par * 2 * half);
  endfunction

  function automatic int tw_width(input int n_pt, input int par);
    return clog2_min1(n_pt / (2 * par));
  endfunction

  // Twiddle index is the beat position within the B halves of the frame.
  function automatic int tw_compose(input int blk, input int beat, input int half);
    return blk * half + beat;
  endfunction

  localparam int DEF_PAR         = 16;
  localparam int DEF_N_PT        = 512;
  localparam int DEF_HALF_BEATS  = 2;
  localparam int BEATS_PER_FRAME = beats_per_frame(DEF_N_PT, DEF_PAR);
  localparam int BLKS_PER_FRAME  = blks_per_frame(DEF_N_PT, DEF_PAR, DEF_HALF_BEATS);
  localparam int TW_W            = tw_width(DEF_N_PT, DEF_PAR);

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-latency delay for the output qualifiers so they line up with the
// butterfly pipeline. DEPTH = 0 degenerates to a wire.
module valid_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe [DEPTH];

      // NOTE: this is a short qualifier pipe, not a storage array, so every
      // stage is reset; stale valids must never leak out after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: frames beats into FILL/BFLY halves,
// drives shift/butterfly/mux/twiddle, drains on flush. Optional error flag:
// define FFT_SDF_CTRL_ERR_CHK_EN.
module fft_sdf_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int PAR        = DEF_PAR,
  parameter int N_PT       = DEF_N_PT,
  parameter int HALF_BEATS = DEF_HALF_BEATS,
  parameter int BF_LAT     = 1,
  parameter int FCNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              din_valid,
  input  logic                              din_sof,
  input  logic                              flush,
  output logic                              sr_shift_en,
  output logic                              bf_en,
  output logic                              out_sel,
  output logic [tw_width(N_PT, PAR)-1:0]    tw_idx,
  output logic                              dout_valid,
  output logic                              dout_sof,
  output logic                              busy,
  output logic [FCNT_W-1:0]                 frame_cnt
`ifdef FFT_SDF_CTRL_ERR_CHK_EN
  ,
  output logic                              err_sticky
`endif
);

  localparam int TWW    = tw_width(N_PT, PAR);
  localparam int BLKS   = blks_per_frame(N_PT, PAR, HALF_BEATS);
  localparam int BEAT_W = clog2_min1(HALF_BEATS);
  localparam int BLK_W  = clog2_min1(BLKS);

  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(HALF_BEATS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLKS - 1);
  // The frame-start beat is itself the first FILL beat, so counting resumes at 1.
  localparam logic [BEAT_W-1:0] BEAT_FIRST = (HALF_BEATS == 1) ? '0 : BEAT_W'(1);
  localparam logic [1:0]        ST_FIRST   = (HALF_BEATS == 1) ? ST_BFLY : ST_FILL;

  logic [1:0]        state, state_d;
  logic [BEAT_W-1:0] beat, beat_d;
  logic [BLK_W-1:0]  blk, blk_d;
  logic              pend, pend_d;
  logic [FCNT_W-1:0] fcnt_d;
  logic              shift, bf, sel, emit, sof_src, start_frame, misaligned;
  logic [TWW-1:0]    tw_val;

`ifdef FFT_SDF_CTRL_ERR_CHK_EN
  assign misaligned = din_valid && din_sof && (state == ST_FILL || state == ST_BFLY)
                      && !(state == ST_FILL && beat == '0 && blk == '0);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    beat_d      = beat;
    blk_d       = blk;
    pend_d      = pend;
    fcnt_d      = frame_cnt;
    shift       = 1'b0;
    bf          = 1'b0;
    sel         = 1'b0;
    emit        = 1'b0;
    sof_src     = 1'b0;
    tw_val      = '0;
    start_frame = 1'b0;

    case (state)
      ST_IDLE: begin
        if (din_valid && din_sof) begin
          start_frame = 1'b1;
        end else if (!din_valid && flush && pend) begin
          state_d = ST_DRAIN;
          beat_d  = '0;
        end
      end
      ST_FILL: begin
        if (din_valid && misaligned) begin
          start_frame = 1'b1;
        end else if (din_valid) begin
          shift = 1'b1;
          sel   = pend;
          emit  = pend;
          if (beat == BEAT_LAST) begin
            state_d = ST_BFLY;
            beat_d  = '0;
          end else begin
            beat_d = beat + 1'b1;
          end
        end else if (flush && beat == '0) begin
          state_d = pend ? ST_DRAIN : ST_IDLE;
          beat_d  = '0;
          blk_d   = '0;
        end
      end
      ST_BFLY: begin
        if (din_valid && misaligned) begin
          start_frame = 1'b1;
        end else if (din_valid) begin
          shift   = 1'b1;
          bf      = 1'b1;
          emit    = 1'b1;
          sof_src = (beat == '0) && (blk == '0);
          tw_val  = TWW'(tw_compose(int'(blk), int'(beat), HALF_BEATS));
          if (beat == BEAT_LAST) begin
            state_d = ST_FILL;
            beat_d  = '0;
            pend_d  = 1'b1;
            if (blk == BLK_LAST) begin
              blk_d  = '0;
              fcnt_d = frame_cnt + 1'b1;
            end else begin
              blk_d = blk + 1'b1;
            end
          end else begin
            beat_d = beat + 1'b1;
          end
        end
      end
      default: begin
        // DRAIN runs every cycle regardless of input; incoming beats are dropped.
        shift = 1'b1;
        sel   = 1'b1;
        emit  = 1'b1;
        if (beat == BEAT_LAST) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          pend_d  = 1'b0;
        end else begin
          beat_d = beat + 1'b1;
        end
      end
    endcase

    if (start_frame) begin
      shift   = 1'b1;
      bf      = 1'b0;
      sel     = pend;
      emit    = pend;
      sof_src = 1'b0;
      tw_val  = '0;
      state_d = ST_FIRST;
      beat_d  = BEAT_FIRST;
      blk_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat      <= '0;
      blk       <= '0;
      pend      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      blk       <= blk_d;
      pend      <= pend_d;
      frame_cnt <= fcnt_d;
    end
  end

`ifdef FFT_SDF_CTRL_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)                                          err_sticky <= 1'b0;
    else if (misaligned || (state == ST_DRAIN && din_valid)) err_sticky <= 1'b1;
  end
`endif

  // Reset blanks the strobes in the same cycle so an abort never moves the datapath.
  assign sr_shift_en = shift & ~rst;
  assign bf_en       = bf & ~rst;
  assign out_sel     = sel & ~rst;
  assign tw_idx      = rst ? '0 : tw_val;
  assign busy        = (state != ST_IDLE);

  valid_delay_line #(
    .DEPTH (BF_LAT),
    .WIDTH (2)
  ) u_vdl (
    .clk  (clk),
    .rst  (rst),
    .din  ({sof_src, emit}),
    .dout ({dout_sof, dout_valid})
  );

endmodule
